// File: rtl/sc_frogger_game_controller.sv
// Frogger game-sequencing FSM: start/press handling, step/clear/respawn pulses,
// and level/lives bookkeeping driven by the last-register comparator result.
module sc_frogger_game_controller #(
    parameter int unsigned LEVEL_WIDTH = 3,
    parameter int unsigned MAX_LEVEL   = 4,
    parameter int unsigned LIVES_WIDTH = 2,
    parameter int unsigned LIVES_INIT  = 3
) (
    input  logic                   SC_FROGGERCTRL_CLOCK_50,
    input  logic                   SC_FROGGERCTRL_RESET_InLow,
    input  logic                   SC_FROGGERCTRL_start_InLow,
    input  logic                   SC_FROGGERCTRL_tick_In,
    input  logic [1:0]             SC_FROGGERCTRL_result_InBUS,
    output logic                   SC_FROGGERCTRL_step_Out,
    output logic                   SC_FROGGERCTRL_clear_Out,
    output logic                   SC_FROGGERCTRL_respawn_Out,
    output logic [LEVEL_WIDTH-1:0] SC_FROGGERCTRL_level_OutBUS,
    output logic [LIVES_WIDTH-1:0] SC_FROGGERCTRL_lives_OutBUS,
    output logic                   SC_FROGGERCTRL_gameover_Out,
    output logic                   SC_FROGGERCTRL_winner_Out
);

    localparam logic [LEVEL_WIDTH-1:0] LEVEL_LAST  = LEVEL_WIDTH'(MAX_LEVEL - 1);
    localparam logic [LIVES_WIDTH-1:0] LIVES_START = LIVES_WIDTH'(LIVES_INIT);
    localparam logic [LIVES_WIDTH-1:0] LIVES_ONE   = LIVES_WIDTH'(1);
    localparam logic [LEVEL_WIDTH-1:0] LEVEL_ONE   = LEVEL_WIDTH'(1);

    typedef enum logic [3:0] {
        S_IDLE, S_LOAD, S_PLAY, S_STEP, S_CHECK,
        S_HIT, S_RESPAWN, S_LEVELUP, S_GAMEOVER, S_WON
    } state_t;

    state_t state, next_state;

    logic                   clk, rst_n;
    logic [2:0]             sync;
    logic                   press;
    logic [LEVEL_WIDTH-1:0] level;
    logic [LIVES_WIDTH-1:0] lives;
    logic                   step_d, clear_d, respawn_d, gameover_d, winner_d;

    assign clk   = SC_FROGGERCTRL_CLOCK_50;
    assign rst_n = SC_FROGGERCTRL_RESET_InLow;

    // Two-flop synchronizer plus edge flop; press is one cycle per falling edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) sync <= 3'b111;
        else        sync <= {sync[1:0], SC_FROGGERCTRL_start_InLow};
    end

    assign press = ~sync[1] & sync[2];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            S_IDLE:     if (press) next_state = S_LOAD;
            S_LOAD:     next_state = S_PLAY;
            S_PLAY:     if (SC_FROGGERCTRL_tick_In) next_state = S_STEP;
            S_STEP:     next_state = S_CHECK;
            S_CHECK: begin
                case (SC_FROGGERCTRL_result_InBUS)
                    2'b00:   next_state = S_LEVELUP;
                    2'b10:   next_state = S_HIT;
                    default: next_state = S_PLAY;
                endcase
            end
            S_HIT:      next_state = (lives <= LIVES_ONE) ? S_GAMEOVER : S_RESPAWN;
            S_RESPAWN:  next_state = S_PLAY;
            S_LEVELUP:  next_state = (level == LEVEL_LAST) ? S_WON : S_LOAD;
            S_GAMEOVER: if (press) next_state = S_IDLE;
            S_WON:      if (press) next_state = S_IDLE;
            default:    next_state = S_IDLE;
        endcase
    end

    // Outputs are decoded from the upcoming state so the flops track the state register.
    always_comb begin
        step_d     = 1'b0;
        clear_d    = 1'b0;
        respawn_d  = 1'b0;
        gameover_d = 1'b0;
        winner_d   = 1'b0;
        case (next_state)
            S_STEP:     step_d     = 1'b1;
            S_LOAD:     clear_d    = 1'b1;
            S_RESPAWN:  respawn_d  = 1'b1;
            S_GAMEOVER: gameover_d = 1'b1;
            S_WON:      winner_d   = 1'b1;
            default:    ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            SC_FROGGERCTRL_step_Out     <= 1'b0;
            SC_FROGGERCTRL_clear_Out    <= 1'b0;
            SC_FROGGERCTRL_respawn_Out  <= 1'b0;
            SC_FROGGERCTRL_gameover_Out <= 1'b0;
            SC_FROGGERCTRL_winner_Out   <= 1'b0;
        end else begin
            SC_FROGGERCTRL_step_Out     <= step_d;
            SC_FROGGERCTRL_clear_Out    <= clear_d;
            SC_FROGGERCTRL_respawn_Out  <= respawn_d;
            SC_FROGGERCTRL_gameover_Out <= gameover_d;
            SC_FROGGERCTRL_winner_Out   <= winner_d;
        end
    end

    // Saturating level/lives counters; they only move in IDLE, HIT and LEVELUP.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            level <= '0;
            lives <= LIVES_START;
        end else begin
            case (state)
                S_IDLE: begin
                    if (press) begin
                        level <= '0;
                        lives <= LIVES_START;
                    end
                end
                S_HIT: begin
                    if (lives <= LIVES_ONE) lives <= '0;
                    else                    lives <= lives - LIVES_ONE;
                end
                S_LEVELUP: begin
                    if (level != LEVEL_LAST) level <= level + LEVEL_ONE;
                end
                default: ;
            endcase
        end
    end

    assign SC_FROGGERCTRL_level_OutBUS = level;
    assign SC_FROGGERCTRL_lives_OutBUS = lives;

endmodule
